// File: rtl/usb_link_scheduler.sv
// Half-duplex USB link scheduler: round-robin grant of endpoint TX queues, byte streaming
// to the transceiver, RX turnaround, inter-packet gap and bounded reply wait.
module usb_link_scheduler #(
   parameter int unsigned N_REQ        = 4,
   parameter int unsigned GAP_CYCLES   = 8,
   parameter int unsigned RESP_TIMEOUT = 255
) (
   input  logic                     clk,
   input  logic                     nRST,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [8*N_REQ-1:0]       req_data,
   input  logic [N_REQ-1:0]         req_last,
   input  logic [N_REQ-1:0]         req_expect_resp,
   output logic [N_REQ-1:0]         req_pop,
   output logic [N_REQ-1:0]         grant,
   output logic [7:0]               tx_data,
   output logic                     tx_valid,
   input  logic                     tx_accept,
   input  logic                     tx_done,
   input  logic                     rx_active,
   input  logic                     rx_eop,
   output logic                     resp_timeout,
   output logic [$clog2(N_REQ)-1:0] timeout_id,
   output logic                     busy
);

   localparam int unsigned IDX_W = $clog2(N_REQ);
   localparam int unsigned CND_W = IDX_W + 1;
   localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
   localparam int unsigned RSP_W = $clog2(RESP_TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      SEND  = 3'd2,
      DRAIN = 3'd3,
      RESP  = 3'd4,
      RX    = 3'd5,
      GAP   = 3'd6
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] g_idx;
   logic             last_q;
   logic             expect_q;
   logic [GAP_W-1:0] gap_cnt;
   logic [RSP_W-1:0] resp_cnt;

   logic [IDX_W-1:0] pick_idx;
   logic             pick_found;
   logic [CND_W-1:0] cand;

   // Round-robin search starting at rr_ptr, wrapping modulo N_REQ
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         cand = CND_W'(rr_ptr) + CND_W'(k);
         if (cand >= CND_W'(N_REQ)) begin
            cand = cand - CND_W'(N_REQ);
         end
         if (!pick_found && req_valid[cand[IDX_W-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = cand[IDX_W-1:0];
         end
      end
   end

   // Consume pulse must land in the accept cycle so the source advances before the next LOAD
   assign req_pop = (state == SEND && tx_accept) ? grant : '0;

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         g_idx        <= '0;
         last_q       <= 1'b0;
         expect_q     <= 1'b0;
         gap_cnt      <= '0;
         resp_cnt     <= '0;
         grant        <= '0;
         tx_data      <= '0;
         tx_valid     <= 1'b0;
         resp_timeout <= 1'b0;
         timeout_id   <= '0;
         busy         <= 1'b0;
      end else begin
         resp_timeout <= 1'b0;
         unique case (state)
            IDLE: begin
               if (rx_active) begin
                  state <= RX;
                  busy  <= 1'b1;
               end else if (pick_found) begin
                  state    <= LOAD;
                  busy     <= 1'b1;
                  g_idx    <= pick_idx;
                  grant    <= N_REQ'(1'b1) << pick_idx;
                  expect_q <= req_expect_resp[pick_idx];
               end
            end
            LOAD: begin
               if (req_valid[g_idx]) begin
                  tx_data  <= req_data[8*g_idx +: 8];
                  last_q   <= req_last[g_idx];
                  tx_valid <= 1'b1;
                  state    <= SEND;
               end
            end
            SEND: begin
               if (tx_accept) begin
                  tx_valid <= 1'b0;
                  state    <= last_q ? DRAIN : LOAD;
               end
            end
            DRAIN: begin
               if (tx_done) begin
                  rr_ptr <= (g_idx == IDX_W'(N_REQ - 1)) ? '0 : g_idx + IDX_W'(1);
                  grant  <= '0;
                  if (expect_q) begin
                     state    <= RESP;
                     resp_cnt <= '0;
                  end else begin
                     state   <= GAP;
                     gap_cnt <= '0;
                  end
               end
            end
            // Reply start beats the timeout when both land on the final count
            RESP: begin
               if (rx_active) begin
                  state <= RX;
               end else if (resp_cnt == RSP_W'(RESP_TIMEOUT - 1)) begin
                  resp_timeout <= 1'b1;
                  timeout_id   <= g_idx;
                  state        <= GAP;
                  gap_cnt      <= '0;
               end else begin
                  resp_cnt <= resp_cnt + RSP_W'(1);
               end
            end
            RX: begin
               if (rx_eop) begin
                  state   <= GAP;
                  gap_cnt <= '0;
               end
            end
            GAP: begin
               if (rx_active) begin
                  state <= RX;
               end else if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_usb_link_scheduler.sv
// Directed bench for usb_link_scheduler: FIFO-backed packet sources, auto-accepting
// transceiver with delayed tx_done, and hand-computed expectations.
module tb_usb_link_scheduler;

   localparam int unsigned N_REQ        = 4;
   localparam int unsigned GAP_CYCLES   = 8;
   localparam int unsigned RESP_TIMEOUT = 10;
   localparam int unsigned IDX_W        = 2;

   logic               clk = 1'b0;
   logic               nRST;
   logic [N_REQ-1:0]   req_valid;
   logic [8*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]   req_last;
   logic [N_REQ-1:0]   req_expect_resp;
   logic [N_REQ-1:0]   req_pop;
   logic [N_REQ-1:0]   grant;
   logic [7:0]         tx_data;
   logic               tx_valid;
   logic               tx_accept;
   logic               tx_done;
   logic               rx_active;
   logic               rx_eop;
   logic               resp_timeout;
   logic [IDX_W-1:0]   timeout_id;
   logic               busy;

   always #5 clk = ~clk;

   usb_link_scheduler #(
      .N_REQ        (N_REQ),
      .GAP_CYCLES   (GAP_CYCLES),
      .RESP_TIMEOUT (RESP_TIMEOUT)
   ) dut (
      .clk             (clk),
      .nRST            (nRST),
      .req_valid       (req_valid),
      .req_data        (req_data),
      .req_last        (req_last),
      .req_expect_resp (req_expect_resp),
      .req_pop         (req_pop),
      .grant           (grant),
      .tx_data         (tx_data),
      .tx_valid        (tx_valid),
      .tx_accept       (tx_accept),
      .tx_done         (tx_done),
      .rx_active       (rx_active),
      .rx_eop          (rx_eop),
      .resp_timeout    (resp_timeout),
      .timeout_id      (timeout_id),
      .busy            (busy)
   );

   // Packet sources: one byte FIFO per requester, flushed on reset
   logic [7:0]       src_d  [N_REQ][32];
   logic             src_l  [N_REQ][32];
   logic [4:0]       wr_ptr [N_REQ];
   logic [4:0]       rd_ptr [N_REQ];
   logic [N_REQ-1:0] exp_r;
   logic             auto_acc;
   logic [1:0]       done_dly;

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         req_valid[i]       = (wr_ptr[i] != rd_ptr[i]);
         req_data[8*i +: 8] = src_d[i][rd_ptr[i]];
         req_last[i]        = src_l[i][rd_ptr[i]];
      end
   end
   assign req_expect_resp = exp_r;

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < N_REQ; i++) rd_ptr[i] <= wr_ptr[i];
      end else begin
         for (int i = 0; i < N_REQ; i++) if (req_pop[i]) rd_ptr[i] <= rd_ptr[i] + 5'd1;
      end
   end

   // Transceiver: accepts whenever enabled, reports tx_done two clocks after the last byte
   assign tx_accept = auto_acc & tx_valid;
   assign tx_done   = (done_dly == 2'd1);

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST)                       done_dly <= 2'd0;
      else if (|(req_pop & req_last))  done_dly <= 2'd2;
      else if (done_dly != 2'd0)       done_dly <= done_dly - 2'd1;
   end

   // Event logger with monotonic counters
   int unsigned      cyc      = 0;
   int unsigned      gn       = 0;
   int unsigned      sn       = 0;
   int unsigned      to_cnt   = 0;
   int unsigned      done_cyc = 0;
   int unsigned      idle_cyc = 0;
   int unsigned      pop_cnt [N_REQ];
   logic [N_REQ-1:0] glog   [64];
   int unsigned      gstamp [64];
   logic [7:0]       slog   [64];
   logic [N_REQ-1:0] grant_prev = '0;
   logic             busy_prev  = 1'b0;
   logic             pop_bad    = 1'b0;

   initial for (int i = 0; i < N_REQ; i++) pop_cnt[i] = 0;

   always @(posedge clk) begin
      cyc        <= cyc + 1;
      grant_prev <= grant;
      busy_prev  <= busy;
      if (grant != '0 && grant_prev == '0) begin
         glog[gn[5:0]]   <= grant;
         gstamp[gn[5:0]] <= cyc;
         gn              <= gn + 1;
      end
      if (tx_valid && tx_accept) begin
         slog[sn[5:0]] <= tx_data;
         sn            <= sn + 1;
      end
      for (int i = 0; i < N_REQ; i++) if (req_pop[i]) pop_cnt[i] <= pop_cnt[i] + 1;
      if (resp_timeout)        to_cnt   <= to_cnt + 1;
      if (tx_done)             done_cyc <= cyc;
      if (busy_prev && !busy)  idle_cyc <= cyc;
      if (((req_pop & ~grant) != '0) || !$onehot0(req_pop)) pop_bad <= 1'b1;
   end

   int unsigned vec_cnt = 0;
   int unsigned err_cnt = 0;
   int unsigned base, sbase, pbase, to_base;
   logic [N_REQ-1:0] rr_exp [5];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic push(input int i, input logic [7:0] b, input logic last);
      src_d[i][wr_ptr[i]] = b;
      src_l[i][wr_ptr[i]] = last;
      wr_ptr[i] = wr_ptr[i] + 5'd1;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 600) begin tick(); n++; end
      check_eq(tag, 32'(busy), 32'(0));
   endtask

   task automatic wait_grants(input int unsigned target, input string tag);
      int n = 0;
      while (gn < target && n < 400) begin tick(); n++; end
      check_eq(tag, 32'(gn >= target), 32'(1));
   endtask

   task automatic wait_txdone(input string tag);
      int n = 0;
      while (!tx_done && n < 100) begin tick(); n++; end
      check_eq(tag, 32'(tx_done), 32'(1));
   endtask

   initial begin
      nRST      = 1'b1;
      rx_active = 1'b0;
      rx_eop    = 1'b0;
      auto_acc  = 1'b1;
      exp_r     = '0;
      for (int i = 0; i < N_REQ; i++) wr_ptr[i] = 5'd0;
      rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      #1 nRST = 1'b0;
      tick_n(2);

      check_eq("rst_grant",    32'(grant),        32'(0));
      check_eq("rst_tx_valid", 32'(tx_valid),     32'(0));
      check_eq("rst_tx_data",  32'(tx_data),      32'(0));
      check_eq("rst_busy",     32'(busy),         32'(0));
      check_eq("rst_pop",      32'(req_pop),      32'(0));
      check_eq("rst_timeout",  32'(resp_timeout), 32'(0));

      // Round robin: 13 clocks per 1-byte packet (grant, LOAD, SEND, 2-clock drain, 8 gap, IDLE)
      push(0, 8'h10, 1'b1); push(0, 8'h11, 1'b1);
      push(1, 8'h20, 1'b1); push(2, 8'h30, 1'b1); push(3, 8'h40, 1'b1);
      base  = gn;
      nRST  = 1'b1;
      wait_grants(base + 5, "rr_grants");
      for (int k = 0; k < 5; k++)
         check_eq($sformatf("rr_grant%0d", k), 32'(glog[6'(base + k)]), 32'(rr_exp[k]));
      for (int k = 1; k < 5; k++)
         check_eq($sformatf("rr_period%0d", k),
                  gstamp[6'(base + k)] - gstamp[6'(base + k - 1)], 32'(13));
      wait_idle("rr_idle");

      // Single 3-byte packet from requester 2
      base  = gn;
      sbase = sn;
      pbase = pop_cnt[2];
      push(2, 8'hA1, 1'b0); push(2, 8'hA2, 1'b0); push(2, 8'hA3, 1'b1);
      wait_grants(base + 1, "sp_grant_seen");
      check_eq("sp_grant", 32'(glog[6'(base)]), 32'(4'b0100));
      wait_idle("sp_idle");
      tick();
      check_eq("sp_nbytes", sn - sbase, 32'(3));
      check_eq("sp_byte0",  32'(slog[6'(sbase)]),     32'(8'hA1));
      check_eq("sp_byte1",  32'(slog[6'(sbase + 1)]), 32'(8'hA2));
      check_eq("sp_byte2",  32'(slog[6'(sbase + 2)]), 32'(8'hA3));
      check_eq("sp_pops",   pop_cnt[2] - pbase, 32'(3));
      // busy is seen low at the edge after the GAP -> IDLE edge
      check_eq("sp_gap_len", idle_cyc - done_cyc, 32'(GAP_CYCLES + 1));

      // rr_ptr is now 3: requester 3 must win over requester 0
      base = gn;
      push(0, 8'h50, 1'b1); push(3, 8'h53, 1'b1);
      wait_grants(base + 2, "ptr_grants");
      check_eq("ptr_first",  32'(glog[6'(base)]),     32'(4'b1000));
      check_eq("ptr_second", 32'(glog[6'(base + 1)]), 32'(4'b0001));
      wait_idle("ptr_idle");

      // Collision: RX beats a same-cycle request
      rx_active = 1'b1;
      push(0, 8'hD0, 1'b1);
      tick();
      check_eq("col_busy",  32'(busy),  32'(1));
      check_eq("col_grant", 32'(grant), 32'(0));
      tick_n(3);
      check_eq("col_grant_rx", 32'(grant), 32'(0));
      rx_active = 1'b0;
      rx_eop    = 1'b1;
      tick();
      rx_eop = 1'b0;
      tick_n(8);
      check_eq("col_grant_gap", 32'(grant), 32'(0));
      tick();
      check_eq("col_grant_after", 32'(grant), 32'(4'b0001));
      wait_idle("col_idle");

      // Reply timeout from requester 1
      to_base  = to_cnt;
      exp_r[1] = 1'b1;
      push(1, 8'hB1, 1'b0); push(1, 8'hB2, 1'b1);
      wait_txdone("to_txdone");
      tick();
      tick_n(9);
      check_eq("to_early", 32'(resp_timeout), 32'(0));
      tick();
      check_eq("to_pulse", 32'(resp_timeout), 32'(1));
      check_eq("to_id",    32'(timeout_id),   32'(1));
      tick();
      check_eq("to_pulse_end", 32'(resp_timeout), 32'(0));
      check_eq("to_id_held",   32'(timeout_id),   32'(1));
      check_eq("to_count",     to_cnt - to_base,  32'(1));
      wait_idle("to_idle");

      // Reply starts at RESP cycle 5
      to_base = to_cnt;
      push(1, 8'hB3, 1'b1);
      wait_txdone("rep_txdone");
      tick();
      tick_n(5);
      rx_active = 1'b1;
      tick_n(11);
      check_eq("rep_no_timeout", to_cnt - to_base, 32'(0));
      check_eq("rep_busy_rx",    32'(busy),        32'(1));
      rx_active = 1'b0;
      rx_eop    = 1'b1;
      tick();
      rx_eop = 1'b0;
      tick_n(7);
      check_eq("rep_gap_busy", 32'(busy), 32'(1));
      tick();
      check_eq("rep_gap_done", 32'(busy), 32'(0));

      // Reply starts on the final count: RX wins, no timeout
      push(1, 8'hB4, 1'b1);
      wait_txdone("edge_txdone");
      tick();
      tick_n(9);
      rx_active = 1'b1;
      tick();
      check_eq("edge_no_pulse", 32'(resp_timeout), 32'(0));
      tick_n(10);
      check_eq("edge_busy_rx", 32'(busy),        32'(1));
      check_eq("edge_count",   to_cnt - to_base, 32'(0));
      rx_active = 1'b0;
      rx_eop    = 1'b1;
      tick();
      rx_eop = 1'b0;
      exp_r  = '0;
      wait_idle("edge_idle");

      // Held byte, then source underrun on requester 3, then reset while stalled
      auto_acc = 1'b0;
      pbase    = pop_cnt[3];
      push(3, 8'hC1, 1'b0);
      for (int n = 0; n < 50 && !tx_valid; n++) tick();
      check_eq("ur_tx_valid",   32'(tx_valid), 32'(1));
      check_eq("ur_tx_data",    32'(tx_data),  32'(8'hC1));
      check_eq("ur_grant",      32'(grant),    32'(4'b1000));
      tick_n(3);
      check_eq("hold_tx_valid", 32'(tx_valid),         32'(1));
      check_eq("hold_no_pop",   pop_cnt[3] - pbase,    32'(0));
      auto_acc = 1'b1;
      tick();
      tick_n(2);
      check_eq("ur_stall_valid", 32'(tx_valid),      32'(0));
      check_eq("ur_stall_grant", 32'(grant),         32'(4'b1000));
      check_eq("ur_stall_busy",  32'(busy),          32'(1));
      check_eq("ur_pop",         pop_cnt[3] - pbase, 32'(1));
      nRST = 1'b0;
      #1;
      check_eq("mrst_grant",    32'(grant),        32'(0));
      check_eq("mrst_tx_valid", 32'(tx_valid),     32'(0));
      check_eq("mrst_tx_data",  32'(tx_data),      32'(0));
      check_eq("mrst_busy",     32'(busy),         32'(0));
      check_eq("mrst_pop",      32'(req_pop),      32'(0));
      check_eq("mrst_timeout",  32'(resp_timeout), 32'(0));
      check_eq("mrst_id",       32'(timeout_id),   32'(0));
      tick_n(2);
      nRST = 1'b1;
      base = gn;
      push(0, 8'hE0, 1'b1); push(2, 8'hE2, 1'b1);
      wait_grants(base + 2, "mrst_grants");
      check_eq("mrst_rr_first",  32'(glog[6'(base)]),     32'(4'b0001));
      check_eq("mrst_rr_second", 32'(glog[6'(base + 1)]), 32'(4'b0100));
      wait_idle("mrst_idle");

      check_eq("pop_subset_grant", 32'(pop_bad), 32'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/usb_link_scheduler.md
# usb_link_scheduler

Half-duplex link scheduler that sits between several packet sources (endpoint TX queues) and the USB transceiver. It arbitrates round-robin among requesters and streams the granted packet into the transceiver byte by byte. It also enforces bus turnaround: no TX while RX is active, a fixed inter-packet gap after every packet, and a bounded wait for a handshake reply.

## Interface
- N_REQ, 4, number of requesters (2..8)
- GAP_CYCLES, 8, idle clocks enforced after any TX or RX packet before the next grant (≥1)
- RESP_TIMEOUT, 255, clocks to wait for a reply to start after a TX packet that expects one (≥1)

Ports:
- clk  in  1  system clock
- nRST  in  1  reset; asynchronous, active-low
- req_valid  in  N_REQ  requester i has a packet byte available
- req_data  in  8*N_REQ  byte from requester i at [8i+7:8i]
- req_last  in  N_REQ  the current byte of requester i is the last byte of its packet
- req_expect_resp  in  N_REQ  the packet of requester i expects a reply; sampled at grant
- req_pop  out  N_REQ  one-hot single-cycle pulse: current byte of the granted requester consumed
- grant  out  N_REQ  one-hot current owner; 0 when no owner
- tx_data  out  8  byte to transceiver
- tx_valid  out  1  tx_data is valid
- tx_accept  in  1  transceiver took tx_data (pulse)
- tx_done  in  1  transceiver finished the packet, including EOP (pulse)
- rx_active  in  1  transceiver is receiving
- rx_eop  in  1  end of received packet (pulse)
- resp_timeout  out  1  pulse: no reply started within RESP_TIMEOUT
- timeout_id  out  $clog2(N_REQ)  requester index for the last resp_timeout; held until the next timeout
- busy  out  1  state ≠ IDLE

## Operation
States and transitions:
- IDLE
  - rx_active → RX. RX wins over any req_valid in the same cycle.
  - else any req_valid → LOAD. Round-robin pick starts at rr_ptr; grant set; expect_resp latched from req_expect_resp.
- LOAD
  - If req_valid[g] is high: latch req_data[g] into tx_data, latch req_last[g] into last_q, tx_valid←1, → SEND.
  - If req_valid[g] is low: stall in LOAD with tx_valid=0 (source underrun; no timeout).
- SEND
  - Hold tx_valid/tx_data until tx_accept.
  - On tx_accept: req_pop[g] pulses that cycle and tx_valid←0.
  - Then last_q → DRAIN, else → LOAD.
- DRAIN
  - Wait for tx_done.
  - On tx_done: rr_ptr←(g+1) mod N_REQ, grant←0.
  - Then expect_resp → RESP, else → GAP.
- RESP
  - resp_cnt increments from 0 each cycle.
  - rx_active → RX.
  - resp_cnt = RESP_TIMEOUT-1 with no rx_active: resp_timeout pulses, timeout_id←g, → GAP.
- RX
  - Wait for rx_eop → GAP. A tx_accept or tx_done seen here is ignored.
- GAP
  - gap_cnt counts GAP_CYCLES clocks, then → IDLE.
  - rx_active during GAP → RX; gap_cnt is cleared and the gap restarts after that RX.

Arbitration:
- Priority is rr_ptr, rr_ptr+1, … with wrap-around modulo N_REQ.
- rr_ptr updates only on packet completion, so every requester is served within N_REQ packets.

Reset (asynchronous, nRST low):
- state=IDLE, rr_ptr=0, all counters 0.
- grant=0, req_pop=0, tx_valid=0, tx_data=0, resp_timeout=0, timeout_id=0, busy=0.
- Reset mid-packet drops the packet silently; requesters must flush on reset.

Other rules:
- Requests that appear while a packet is in flight wait; no preemption.
- req_pop is always a subset of grant.

## Timing
- Grant latency: req_valid sampled in IDLE → grant and state LOAD at the next edge; tx_valid high one edge later.
- Byte pacing:
  - Minimum 2 clocks per byte (LOAD then SEND) when tx_accept arrives the first SEND cycle.
  - tx_valid drops for exactly one cycle between bytes.
- req_pop is asserted combinationally in the tx_accept cycle; the requester advances req_data at the following edge, before the next LOAD.
- GAP lasts exactly GAP_CYCLES clocks: first GAP cycle through return to IDLE.
- Timeout fires RESP_TIMEOUT clocks after entering RESP.
- If rx_active and the final count coincide, rx_active wins and there is no timeout.
- tx_done outside DRAIN and rx_eop outside RX are ignored.

## Test plan
- Single packet: req 2 sends 3 bytes A1 A2 A3, expect_resp=0, tx_accept the first SEND cycle. Required:
  - grant=0100.
  - tx_data sequence A1, A2, A3 with three req_pop[2] pulses.
  - tx_done → exactly 8 GAP cycles → IDLE.
  - rr_ptr=3.
- Round robin: all 4 req_valid held, 1-byte packets. Required: grants in the order 0,1,2,3,0, with a gap between each.
- Collision: rx_active and req_valid[0] rise in the same IDLE cycle. Required:
  - RX is entered and grant stays 0.
  - After rx_eop + 8 gap cycles, req 0 is granted.
- Response timeout: RESP_TIMEOUT=10, req 1 sends a packet with expect_resp=1, no rx_active. Required: resp_timeout pulses 10 cycles after tx_done, with timeout_id=1.
- Reply in time: same setup, with rx_active at RESP cycle 5. Required: no timeout; RX, then GAP.
- Underrun and reset: req_valid[3] drops mid-packet. Required:
  - tx_valid=0 while stalled in LOAD.
  - nRST asserted while stalled: all outputs 0 immediately; IDLE with rr_ptr=0 after release.
